// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: round-robin grant among result producers, one-cycle registered
// broadcast, with squash of speculative packets on a branch mispredict in the grant cycle.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ           = 4,
    parameter int unsigned BW_TAG            = 6,
    parameter int unsigned BW_PROCESSOR_DATA = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    i_req_valid,
    output logic [NUM_REQ-1:0]                    i_req_ready,
    input  logic [NUM_REQ*BW_TAG-1:0]             i_req_tag_flatten,
    input  logic [NUM_REQ*BW_PROCESSOR_DATA-1:0]  i_req_data_flatten,
    input  logic [NUM_REQ-1:0]                    i_req_speculation,
    input  logic                                  i_branch_valid,
    input  logic                                  i_branch_correct_prediction,
    output logic                                  o_cdb_valid,
    output logic [BW_TAG-1:0]                     o_cdb_tag,
    output logic signed [BW_PROCESSOR_DATA-1:0]   o_cdb_data,
    output logic                                  o_cdb_speculation
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;

    logic [PTR_W-1:0]             ptr_q, ptr_d;
    logic [PTR_W-1:0]             gnt_idx;
    logic [PTR_W-1:0]             scan_idx;
    logic [SUM_W-1:0]             scan_sum;
    logic [NUM_REQ-1:0]           grant;
    logic                         found;
    logic [BW_TAG-1:0]            sel_tag;
    logic [BW_PROCESSOR_DATA-1:0] sel_data;
    logic                         sel_spec;
    logic                         squash;

    logic                         cdb_valid_q, cdb_valid_d;
    logic [BW_TAG-1:0]            cdb_tag_q;
    logic [BW_PROCESSOR_DATA-1:0] cdb_data_q;
    logic                         cdb_spec_q, cdb_spec_d;

    // Scan from ptr upwards, wrapping; the first valid requester wins.
    always_comb begin
        grant    = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        sel_tag  = '0;
        sel_data = '0;
        sel_spec = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_sum = {1'b0, ptr_q} + SUM_W'(i);
            if (scan_sum >= SUM_W'(NUM_REQ)) begin
                scan_sum = scan_sum - SUM_W'(NUM_REQ);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!found && i_req_valid[scan_idx]) begin
                found           = 1'b1;
                gnt_idx         = scan_idx;
                grant[scan_idx] = 1'b1;
                sel_tag         = i_req_tag_flatten[scan_idx*BW_TAG +: BW_TAG];
                sel_data        = i_req_data_flatten[scan_idx*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
                sel_spec        = i_req_speculation[scan_idx];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // A mispredict drops a speculative packet but the handshake still completes.
    assign squash      = found && sel_spec && i_branch_valid && !i_branch_correct_prediction;
    assign cdb_valid_d = found && !squash;
    assign cdb_spec_d  = sel_spec && !i_branch_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_spec_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            cdb_valid_q <= cdb_valid_d;
            if (cdb_valid_d) begin
                cdb_tag_q  <= sel_tag;
                cdb_data_q <= sel_data;
                cdb_spec_q <= cdb_spec_d;
            end
        end
    end

    assign i_req_ready       = grant & {NUM_REQ{rst_n}};
    assign o_cdb_valid       = cdb_valid_q;
    assign o_cdb_tag         = cdb_tag_q;
    assign o_cdb_data        = cdb_data_q;
    assign o_cdb_speculation = cdb_spec_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: grant order, latency, wrap, squash,
// speculation resolve and asynchronous reset.
module tb_cdb_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned TW = 6;
    localparam int unsigned DW = 32;

    logic                 clk;
    logic                 rst_n;
    logic [NR-1:0]        req_valid;
    logic [NR-1:0]        req_ready;
    logic [NR*TW-1:0]     tag_flat;
    logic [NR*DW-1:0]     data_flat;
    logic [NR-1:0]        req_spec;
    logic                 br_valid;
    logic                 br_correct;
    logic                 cdb_valid;
    logic [TW-1:0]        cdb_tag;
    logic signed [DW-1:0] cdb_data;
    logic                 cdb_spec;

    logic [TW-1:0]        tag_a  [NR];
    logic [DW-1:0]        data_a [NR];
    logic [NR-1:0]        pend;
    int                   n_checks;
    int                   n_fail;

    cdb_arbiter #(
        .NUM_REQ          (NR),
        .BW_TAG           (TW),
        .BW_PROCESSOR_DATA(DW)
    ) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .i_req_valid                (req_valid),
        .i_req_ready                (req_ready),
        .i_req_tag_flatten          (tag_flat),
        .i_req_data_flatten         (data_flat),
        .i_req_speculation          (req_spec),
        .i_branch_valid             (br_valid),
        .i_branch_correct_prediction(br_correct),
        .o_cdb_valid                (cdb_valid),
        .o_cdb_tag                  (cdb_tag),
        .o_cdb_data                 (cdb_data),
        .o_cdb_speculation          (cdb_spec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NR; k++) begin
            tag_flat[k*TW +: TW]  = tag_a[k];
            data_flat[k*DW +: DW] = data_a[k];
        end
    end

    // Producer-protocol monitor: a pending request may not drop before its handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NR; k++) begin
                if (pend[k]) begin
                    n_checks++;
                    if (!req_valid[k]) begin
                        n_fail++;
                        $display("FAIL producer_hold[%0d]: valid %b, required 1", k, req_valid[k]);
                    end
                end
            end
            pend = req_valid & ~req_ready;
        end else begin
            pend = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_tags();
        for (int k = 0; k < NR; k++) begin
            tag_a[k]  = TW'(8'h10 + k);
            data_a[k] = 32'hA000_0000 + DW'(k);
        end
    endtask

    task automatic test_reset();
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        n_checks++;
        if ({cdb_valid, cdb_tag, cdb_data, cdb_spec} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b t=%h d=%h s=%b want all 0",
                     cdb_valid, cdb_tag, cdb_data, cdb_spec);
        end
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        req_valid  = 4'b0100;
        tag_a[2]   = 6'h15;
        data_a[2]  = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 6'h15 || cdb_data !== 32'shDEADBEEF || cdb_spec !== 1'b0) begin
            n_fail++;
            $display("FAIL single_bcast: got v=%b t=%h d=%h s=%b want 1 15 deadbeef 0",
                     cdb_valid, cdb_tag, cdb_data, cdb_spec);
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0 || cdb_tag !== 6'h15 || cdb_data !== 32'shDEADBEEF) begin
            n_fail++;
            $display("FAIL single_idle: got v=%b t=%h d=%h want 0 15 deadbeef",
                     cdb_valid, cdb_tag, cdb_data);
        end
    endtask

    // Pointer is 3 after the single-request test.
    task automatic test_wrap();
        tag_a[3]  = 6'h23;
        tag_a[0]  = 6'h20;
        req_valid = 4'b1001;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL wrap_ready3: got %b want 1000", req_ready);
        end
        tick();
        req_valid = 4'b0001;
        #1;
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 6'h23 || req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_grant0: got v=%b t=%h rdy=%b want 1 23 0001", cdb_valid, cdb_tag, req_ready);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 6'h20) begin
            n_fail++; $display("FAIL wrap_bcast0: got v=%b t=%h want 1 20", cdb_valid, cdb_tag);
        end
        tick();
    endtask

    task automatic test_round_robin();
        set_default_tags();
        req_valid = 4'b1000;
        tick();
        req_valid = 4'b1111;
        for (int cyc = 0; cyc < 8; cyc++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'(1 << (cyc % 4))) begin
                n_fail++; $display("FAIL rr_ready[%0d]: got %b want %b", cyc, req_ready, 4'(1 << (cyc % 4)));
            end
            tick();
            n_checks++;
            if (cdb_valid !== 1'b1 || cdb_tag !== TW'(8'h10 + cyc % 4) || cdb_data !== DW'(32'hA000_0000 + cyc % 4)) begin
                n_fail++;
                $display("FAIL rr_bcast[%0d]: got v=%b t=%h d=%h want 1 %h", cyc, cdb_valid, cdb_tag,
                         cdb_data, TW'(8'h10 + cyc % 4));
            end
            if (cyc >= 4) req_valid[cyc % 4] = 1'b0;
        end
    endtask

    task automatic test_squash();
        int order [4] = '{2, 3, 0, 1};
        tag_a[1]    = 6'h07;
        req_spec    = 4'b0010;
        req_valid   = 4'b0010;
        br_valid    = 1'b1;
        br_correct  = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL squash_ready: got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        req_spec  = '0;
        br_valid  = 1'b0;
        n_checks++;
        if (cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL squash_valid: got %b want 0", cdb_valid);
        end
        // The pointer must now be 2: grants follow 2,3,0,1.
        set_default_tags();
        req_valid = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'(1 << order[j])) begin
                n_fail++; $display("FAIL squash_ptr[%0d]: got %b want %b", j, req_ready, 4'(1 << order[j]));
            end
            tick();
            req_valid[order[j]] = 1'b0;
        end
        tick();
    endtask

    // Pointer is 2 here; a lone req 0 is granted regardless.
    task automatic test_resolve();
        logic [2:0] br_vec [3] = '{3'b111, 3'b100, 3'b010};
        logic [1:0] want   [3] = '{2'b10, 2'b11, 2'b10};
        for (int j = 0; j < 3; j++) begin
            logic [2:0] v;
            logic [1:0] w;
            v          = br_vec[j];
            w          = want[j];
            req_spec   = {3'b000, v[2]};
            br_valid   = v[1];
            br_correct = v[0];
            req_valid  = 4'b0001;
            #1;
            n_checks++;
            if (req_ready !== 4'b0001) begin
                n_fail++; $display("FAIL resolve_ready[%0d]: got %b want 0001", j, req_ready);
            end
            tick();
            req_valid = '0;
            req_spec  = '0;
            br_valid  = 1'b0;
            br_correct = 1'b0;
            n_checks++;
            if ({cdb_valid, cdb_spec} !== w || cdb_tag !== 6'h10) begin
                n_fail++;
                $display("FAIL resolve_bcast[%0d]: got v=%b s=%b t=%h want %b 10", j, cdb_valid, cdb_spec,
                         cdb_tag, w);
            end
        end
        tick();
    endtask

    // Pointer is 1 here, so req 2 wins before reset.
    task automatic test_reset_mid();
        req_valid = 4'b0101;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++; $display("FAIL rstmid_pre_ready: got %b want 0100", req_ready);
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 6'h12) begin
            n_fail++; $display("FAIL rstmid_bcast: got v=%b t=%h want 1 12", cdb_valid, cdb_tag);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (cdb_valid !== 1'b0 || req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rstmid_async: got v=%b rdy=%b want 0 0000", cdb_valid, req_ready);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++; $display("FAIL rstmid_first: got %b want 0001", req_ready);
        end
        tick();
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 6'h10 || req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL rstmid_second: got v=%b t=%h rdy=%b want 1 10 0100", cdb_valid, cdb_tag, req_ready);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 6'h12) begin
            n_fail++; $display("FAIL rstmid_bcast2: got v=%b t=%h want 1 12", cdb_valid, cdb_tag);
        end
        tick();
        n_checks++;
        if (cdb_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_idle: got %b want 0", cdb_valid);
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        pend       = '0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_spec   = '0;
        br_valid   = 1'b0;
        br_correct = 1'b0;
        set_default_tags();
        tick();
        test_reset();
        test_single();
        test_wrap();
        test_round_robin();
        test_squash();
        test_resolve();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus between the processor's result producers: the load/store unit, ALU, mul/div and branch units.
- Each producer presents a valid/ready result packet of tag plus data.
- The arbiter grants one producer per cycle using rotating (round-robin) priority.
- The granted packet is registered and broadcast on the CDB the following cycle.
- A granted packet issued under an unresolved branch is squashed if that branch resolves as mispredicted in the grant cycle.

Parameters:
- NUM_REQ, 4, number of CDB producers (at least 2).
- BW_TAG, 6, reservation-station/ROB tag width.
- BW_PROCESSOR_DATA, 32, broadcast data width.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_req_valid  input  NUM_REQ  producer k has a result pending
- i_req_ready  output  NUM_REQ  grant; transfer from k when i_req_valid[k] and i_req_ready[k] are both high
- i_req_tag_flatten  input  NUM_REQ*BW_TAG  tag of k in bits [k*BW_TAG +: BW_TAG]
- i_req_data_flatten  input  NUM_REQ*BW_PROCESSOR_DATA  signed data of k, same packing
- i_req_speculation  input  NUM_REQ  result of k depends on the unresolved branch
- i_branch_valid  input  1  branch resolves this cycle
- i_branch_correct_prediction  input  1  qualifies i_branch_valid; 0 means mispredict
- o_cdb_valid  output  1  broadcast valid; the CDB has no backpressure
- o_cdb_tag  output  BW_TAG  broadcast tag
- o_cdb_data  output  BW_PROCESSOR_DATA  signed broadcast data
- o_cdb_speculation  output  1  broadcast result is still speculative

Behaviour:
- Reset values (asynchronous, on rst_n low):
  - o_cdb_valid=0, o_cdb_tag=0, o_cdb_data=0, o_cdb_speculation=0.
  - Priority pointer ptr=0.
  - i_req_ready=0 during reset.
- Grant logic (combinational from current-cycle inputs and ptr):
  - Scan requesters ptr, ptr+1, ..., ptr+NUM_REQ-1, modulo NUM_REQ. The first one with i_req_valid high is granted, g.
  - i_req_ready is one-hot at bit g, or all-zero if no request is valid.
  - i_req_ready never asserts for a requester whose valid is low.
- Producer rules: valid, tag, data and speculation stay stable until the handshake completes. Dropping valid without a handshake is illegal; the bench asserts on it.
- Pointer update on a grant: ptr <= (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0. With no grant, ptr holds.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Latency: a handshake in cycle t drives o_cdb_* in cycle t+1 (exactly 1 cycle).
  - o_cdb_valid is high for exactly one cycle per accepted packet, unless that packet is squashed.
  - Back-to-back grants give back-to-back broadcasts at full throughput, 1 per cycle.
  - With no handshake in t, o_cdb_valid=0 in t+1; tag and data hold their last values.
- Branch handling, evaluated in the grant cycle t:
  - Mispredict (i_branch_valid=1, i_branch_correct_prediction=0) and i_req_speculation[g]=1:
    - The handshake still completes: i_req_ready[g]=1 and ptr advances.
    - o_cdb_valid=0 in t+1; the packet is dropped.
  - Correct prediction (i_branch_valid=1, i_branch_correct_prediction=1): o_cdb_speculation=0 in t+1, regardless of i_req_speculation[g].
  - No branch event (i_branch_valid=0): o_cdb_speculation=i_req_speculation[g] in t+1.
  - A branch event in t+1 does not retract the broadcast already on the bus in t+1. Consumers handle that packet using o_cdb_speculation.
- Arithmetic: none on the data. Tag and data pass through unmodified and sign is preserved. ptr is ceil(log2(NUM_REQ)) bits, minimum 1.
- Reset mid-operation: the in-flight broadcast is discarded and ptr returns to 0. Pending requesters re-arbitrate from requester 0 after reset deasserts.

Test Plan:
- Single request: req 2 valid with tag=6'h15, data=32'hDEADBEEF at cycle 3 -> ready[2]=1 in cycle 3; cycle 4 o_cdb_valid=1, tag=6'h15, data=32'hDEADBEEF; cycle 5 o_cdb_valid=0.
- All four valid and held, ptr=0 -> grant order 0,1,2,3,0,... on consecutive cycles; o_cdb_valid high continuously, each tag appearing one cycle after its grant.
- Pointer wrap: req 3 then req 0 valid, ptr=3 -> grant 3; ptr becomes 0; grant 0 next cycle; no requester skipped.
- Squash: req 1 speculative, tag=6'h07, granted while i_branch_valid=1 and correct=0 -> ready[1]=1, o_cdb_valid=0 next cycle, ptr=2.
- Resolve: req 0 speculative, granted with i_branch_valid=1 and correct=1 -> next cycle o_cdb_valid=1, o_cdb_speculation=0.
- Reset: rst_n pulled low asynchronously mid-cycle while the broadcast register is valid -> o_cdb_valid=0 immediately, ptr=0; after release, pending req 2 and req 0 grant 0 first.
